// File: rtl/medidor_periodo_pkg.sv
// Shared definitions for the period monitor: FSM encoding and the nominal
// time-base constants that the divider chain and this monitor agree on.
package medidor_periodo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOST    = 2'd2
    } state_t;

    localparam int DEF_WIDTH      = 16;
    localparam int NOMINAL_PERIOD = 512;
    localparam int DEF_TIMEOUT    = 2 * NOMINAL_PERIOD;
    localparam int DEF_PMIN       = NOMINAL_PERIOD - 12;
    localparam int DEF_PMAX       = NOMINAL_PERIOD + 12;

endpackage

// File: rtl/medidor_periodo_sync_edge.sv
// Brings the asynchronous input into the clk domain (two flops) and keeps a
// history flop so a rising edge can be detected on the synchronized level.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic in_sig,
    output logic level,
    output logic rise
);

    logic s1_r;
    logic s2_r;
    logic s3_r;

    // synchronizer chain plus history stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= in_sig;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign level = s2_r;
    assign rise  = s2_r & ~s3_r;

endmodule

// File: rtl/medidor_periodo.sv
// Period monitor: counts clk cycles between rising edges of a slow input,
// reports each completed period, checks it against a window and flags loss.
module medidor_periodo
    import medidor_periodo_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int PMIN    = DEF_PMIN,
    parameter int PMAX    = DEF_PMAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_sig,
    output logic             edge_tick,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    output logic             in_range,
    output logic             lost
);

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] PMIN_W   = WIDTH'(PMIN);
    localparam logic [WIDTH-1:0] PMAX_W   = WIDTH'(PMAX);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_W   = WIDTH'(0);

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_s;
    logic [WIDTH-1:0] cnt_inc_s;
    logic [WIDTH-1:0] period_s;
    logic             in_range_s;
    logic             valid_s;
    logic             edge_s;

    sync_edge u_sync (
        .clk    (clk),
        .rst    (rst),
        .in_sig (in_sig),
        .level  (),
        .rise   (edge_s)
    );

    // TIMEOUT <= 2^WIDTH-1 keeps this from overflowing
    assign cnt_inc_s = cnt_r + ONE_W;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // next state, counter and measurement results
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        period_s   = period;
        in_range_s = in_range;
        valid_s    = 1'b0;
        if (!en) begin
            state_s = ST_IDLE;
            cnt_s   = ZERO_W;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_s = ZERO_W;
                    if (edge_s) begin
                        state_s = ST_MEASURE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_MEASURE: begin
                    // an edge on the last count still closes a valid period
                    if (edge_s) begin
                        period_s   = cnt_inc_s;
                        in_range_s = (cnt_inc_s >= PMIN_W) && (cnt_inc_s <= PMAX_W);
                        valid_s    = 1'b1;
                        cnt_s      = ZERO_W;
                    end else if (cnt_r == CNT_LAST) begin
                        state_s = ST_LOST;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end
                ST_LOST: begin
                    if (edge_s) begin
                        state_s = ST_MEASURE;
                        cnt_s   = ZERO_W;
                    end else begin
                        state_s = ST_LOST;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = ZERO_W;
                end
            endcase
        end
    end

    // counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= ZERO_W;
            edge_tick <= 1'b0;
            period    <= ZERO_W;
            valid     <= 1'b0;
            in_range  <= 1'b0;
            lost      <= 1'b0;
        end else begin
            cnt_r     <= cnt_s;
            edge_tick <= edge_s;
            period    <= period_s;
            valid     <= valid_s;
            in_range  <= in_range_s;
            lost      <= (state_s == ST_LOST);
        end
    end

endmodule

// File: tb/tb_medidor_periodo.sv
// Self-checking bench for medidor_periodo: scoreboard of expected periods
// plus a table of boundary periods and hand-written loss/enable/reset cases.
`timescale 1ns/100ps
module tb_medidor_periodo;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             in_sig;
    logic             edge_tick;
    logic [WIDTH-1:0] period;
    logic             valid;
    logic             in_range;
    logic             lost;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int   period;
        logic ir;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t tab[8];

    always #10 clk = ~clk;

    medidor_periodo #(
        .WIDTH   (WIDTH),
        .TIMEOUT (1024),
        .PMIN    (500),
        .PMAX    (524)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_sig    (in_sig),
        .edge_tick (edge_tick),
        .period    (period),
        .valid     (valid),
        .in_range  (in_range),
        .lost      (lost)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sb_push(input int p, input logic ir);
        exp_t e;
        e.period = p;
        e.ir     = ir;
        exp_q.push_back(e);
    endtask

    // rising edge now, then one full period of p cycles; the edge closes the
    // previous interval, whose expectation is pushed when push is set
    task automatic rise(input int p, input bit push, input int ep, input logic eir);
        if (push) sb_push(ep, eir);
        in_sig = 1'b1;
        tick(p / 2);
        in_sig = 1'b0;
        tick(p - p / 2);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_edge_tick"}, edge_tick, 0);
        chk({tag, "_period"},    period,    0);
        chk({tag, "_valid"},     valid,     0);
        chk({tag, "_in_range"},  in_range,  0);
        chk({tag, "_lost"},      lost,      0);
    endtask

    // scoreboard consumer: every valid strobe must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && valid) begin
            chk("valid_with_edge_tick", edge_tick, 1);
            chk("lost_at_valid", lost, 0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got valid with period=%0d, expected no valid (t=%0t)",
                         period, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("period", period, mon_e.period);
                chk("in_range", in_range, mon_e.ir);
            end
        end
    end

    initial begin
        int n;

        rst    = 1'b1;
        en     = 1'b1;
        in_sig = 1'b0;
        tick(3);
        chk_zero("reset");
        rst = 1'b0;
        tick(5);

        // nominal 512-cycle square wave; first edge only arms
        rise(512, 1'b0, 0, 1'b0);
        repeat (3) rise(512, 1'b1, 512, 1'b1);
        rise(40, 1'b1, 512, 1'b1);
        tick(1200);
        chk("lost_after_silence", lost, 1);

        // period table including window boundaries and exactly TIMEOUT
        tab[0] = '{400,  1'b0};
        tab[1] = '{600,  1'b0};
        tab[2] = '{500,  1'b1};
        tab[3] = '{524,  1'b1};
        tab[4] = '{499,  1'b0};
        tab[5] = '{525,  1'b0};
        tab[6] = '{1024, 1'b0};
        tab[7] = '{512,  1'b1};
        rise(tab[0].period, 1'b0, 0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            rise(tab[i].period, 1'b1, tab[i-1].period, tab[i-1].ir);
        end
        rise(40, 1'b1, tab[7].period, tab[7].ir);
        tick(1200);

        // loss of signal: lost rises 1024 cycles after the last edge_tick
        rise(512, 1'b0, 0, 1'b0);
        rise(512, 1'b1, 512, 1'b1);
        sb_push(512, 1'b1);
        in_sig = 1'b1;
        n = 0;
        while (!edge_tick && n < 10) begin
            tick(1);
            n++;
        end
        chk("edge_tick_before_loss", edge_tick, 1);
        n = 0;
        while (!lost && n < 1200) begin
            tick(1);
            n++;
            if (n == 256) in_sig = 1'b0;
        end
        chk("lost_delay", n, 1024);
        chk("lost_period_hold", period, 512);
        chk("lost_in_range_hold", in_range, 1);
        tick(10);
        chk("lost_before_rearm", lost, 1);
        in_sig = 1'b1;
        n = 0;
        while (!edge_tick && n < 10) begin
            tick(1);
            n++;
        end
        chk("rearm_edge_tick", edge_tick, 1);
        chk("rearm_clears_lost", lost, 0);
        tick(256 - n);
        in_sig = 1'b0;
        tick(256);
        rise(512, 1'b1, 512, 1'b1);
        rise(40, 1'b1, 512, 1'b1);
        tick(1200);

        // enable dropped mid-period: results hold, re-enable needs two edges
        rise(512, 1'b0, 0, 1'b0);
        sb_push(512, 1'b1);
        in_sig = 1'b1;
        tick(100);
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(25);
            chk("en_off_period_hold", period, 512);
            chk("en_off_in_range_hold", in_range, 1);
        end
        en = 1'b1;
        tick(56);
        in_sig = 1'b0;
        tick(256);
        rise(512, 1'b0, 0, 1'b0);
        rise(512, 1'b1, 512, 1'b1);
        rise(40, 1'b1, 512, 1'b1);
        tick(1200);

        // asynchronous reset pulse mid-period
        rise(512, 1'b0, 0, 1'b0);
        sb_push(512, 1'b1);
        in_sig = 1'b1;
        tick(256);
        in_sig = 1'b0;
        tick(100);
        chk("pre_reset_period", period, 512);
        #7 rst = 1'b1;
        #1 chk_zero("async_reset");
        #5 rst = 1'b0;
        tick(155);
        rise(512, 1'b0, 0, 1'b0);
        rise(512, 1'b1, 512, 1'b1);
        rise(40, 1'b1, 512, 1'b1);
        tick(1200);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
